// File: rtl/monitoreo_temperatura_multicanal_pkg.sv
// Shared types for the multi-channel temperature monitor: per-channel FSM state encoding.
package monitoreo_pkg;

  localparam int ESTADO_W = 2;

  typedef enum logic [ESTADO_W-1:0] {
    NORMAL     = 2'b00,
    CALENTANDO = 2'b01,
    ENFRIANDO  = 2'b10,
    ALERTA     = 2'b11
  } estado_t;

endpackage

// File: rtl/monitoreo_temperatura_multicanal_canal.sv
// One monitoring channel: threshold conditions, persistence-filtered entry, hysteresis exit.
// Optional running min/max tracking when MONITOREO_MINMAX_EN is defined.
module monitoreo_canal
  import monitoreo_pkg::*;
#(
  parameter int ANCHO        = 11,
  parameter int PERSISTENCIA = 3,
  parameter int HISTERESIS   = 2,
  parameter int CONT_W       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [ANCHO-1:0] temp,
  input  logic signed [ANCHO-1:0] umbral_bajo,
  input  logic signed [ANCHO-1:0] umbral_alto,
  input  logic signed [ANCHO-1:0] umbral_critico,
`ifdef MONITOREO_MINMAX_EN
  input  logic                    limpiar_minmax,
  output logic signed [ANCHO-1:0] temp_max,
  output logic signed [ANCHO-1:0] temp_min,
`endif
  output estado_t                 estado,
  output logic [CONT_W-1:0]       contador
);

  localparam logic signed [ANCHO:0] HIST = HISTERESIS[ANCHO:0];
  localparam logic [CONT_W:0]       PERS = PERSISTENCIA[CONT_W:0];

  // One extra bit keeps threshold +/- hysteresis free of wrap-around.
  function automatic logic signed [ANCHO:0] extender(input logic signed [ANCHO-1:0] v);
    return {v[ANCHO-1], v};
  endfunction

  logic signed [ANCHO:0] temp_x;
  logic signed [ANCHO:0] lim_bajo, lim_alto, lim_crit;
  logic                  critico, caliente, frio;
  logic                  hay_cand, salida;
  estado_t               cand, cand_prev, destino;
  logic [CONT_W:0]       cuenta_sig;

  assign temp_x   = extender(temp);
  assign lim_bajo = extender(umbral_bajo) + HIST;
  assign lim_alto = extender(umbral_alto) - HIST;
  assign lim_crit = extender(umbral_critico) - HIST;

  always_comb begin
    critico  = temp >= umbral_critico;
    caliente = temp > umbral_alto;
    frio     = temp < umbral_bajo;

    hay_cand = 1'b0;
    cand     = NORMAL;
    if (critico) begin
      hay_cand = 1'b1;
      cand     = ALERTA;
    end else if (caliente && (estado == NORMAL || estado == CALENTANDO)) begin
      hay_cand = 1'b1;
      cand     = ENFRIANDO;
    end else if (frio && estado == NORMAL) begin
      hay_cand = 1'b1;
      cand     = CALENTANDO;
    end

    salida  = 1'b0;
    destino = NORMAL;
    case (estado)
      CALENTANDO: salida = temp_x >= lim_bajo;
      ENFRIANDO:  salida = temp_x <= lim_alto;
      ALERTA: begin
        salida  = temp_x <= lim_crit;
        destino = ENFRIANDO;
      end
      default: salida = 1'b0;
    endcase

    // NORMAL is never a candidate, so it doubles as "no previous candidate".
    if (hay_cand && cand == cand_prev)
      cuenta_sig = {1'b0, contador} + 1'b1;
    else
      cuenta_sig = {{CONT_W{1'b0}}, hay_cand};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= NORMAL;
      contador  <= '0;
      cand_prev <= NORMAL;
    end else if (en) begin
      cand_prev <= cand;
      if (salida) begin
        estado   <= destino;
        contador <= '0;
      end else if (hay_cand && cuenta_sig == PERS) begin
        estado   <= cand;
        contador <= '0;
      end else begin
        contador <= cuenta_sig[CONT_W-1:0];
      end
    end
  end

`ifdef MONITOREO_MINMAX_EN
  logic pendiente;

  always_ff @(posedge clk) begin
    if (rst) begin
      temp_max  <= {1'b1, {(ANCHO-1){1'b0}}};
      temp_min  <= {1'b0, {(ANCHO-1){1'b1}}};
      pendiente <= 1'b0;
    end else if (en) begin
      pendiente <= 1'b0;
      if (pendiente || limpiar_minmax) begin
        temp_max <= temp;
        temp_min <= temp;
      end else begin
        if (temp > temp_max) temp_max <= temp;
        if (temp < temp_min) temp_min <= temp;
      end
    end else if (limpiar_minmax) begin
      pendiente <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/monitoreo_temperatura_multicanal.sv
// Multi-channel temperature monitor top: routes tagged samples to per-channel FSMs.
// Define MONITOREO_MINMAX_EN to add per-channel running min/max ports.
module monitoreo_temperatura_multicanal
  import monitoreo_pkg::*;
#(
  parameter int N_CANALES    = 4,
  parameter int ANCHO        = 11,
  parameter int PERSISTENCIA = 3,
  parameter int HISTERESIS   = 2,
  parameter int CONT_W       = 3,
  localparam int CID_W       = (N_CANALES > 1) ? $clog2(N_CANALES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          temp_valido,
  input  logic [CID_W-1:0]              canal_id,
  input  logic signed [ANCHO-1:0]       temp_entrada,
  input  logic signed [ANCHO-1:0]       umbral_bajo,
  input  logic signed [ANCHO-1:0]       umbral_alto,
  input  logic signed [ANCHO-1:0]       umbral_critico,
`ifdef MONITOREO_MINMAX_EN
  input  logic                          limpiar_minmax,
  output logic [ANCHO*N_CANALES-1:0]    temp_max,
  output logic [ANCHO*N_CANALES-1:0]    temp_min,
`endif
  output logic [N_CANALES-1:0]          calefactor,
  output logic [N_CANALES-1:0]          ventilador,
  output logic [N_CANALES-1:0]          alerta,
  output logic                          alerta_global,
  output logic [ESTADO_W*N_CANALES-1:0] estado_actual,
  output logic [CONT_W*N_CANALES-1:0]   contador_salida
);

  estado_t est [N_CANALES];

  for (genvar c = 0; c < N_CANALES; c++) begin : g_canal
    logic en;
    // Out-of-range channel ids match no instance, so the sample is dropped.
    assign en = temp_valido && (canal_id == CID_W'(c));

    monitoreo_canal #(
      .ANCHO        (ANCHO),
      .PERSISTENCIA (PERSISTENCIA),
      .HISTERESIS   (HISTERESIS),
      .CONT_W       (CONT_W)
    ) u_canal (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .temp           (temp_entrada),
      .umbral_bajo    (umbral_bajo),
      .umbral_alto    (umbral_alto),
      .umbral_critico (umbral_critico),
`ifdef MONITOREO_MINMAX_EN
      .limpiar_minmax (limpiar_minmax),
      .temp_max       (temp_max[ANCHO*c +: ANCHO]),
      .temp_min       (temp_min[ANCHO*c +: ANCHO]),
`endif
      .estado         (est[c]),
      .contador       (contador_salida[CONT_W*c +: CONT_W])
    );

    assign estado_actual[ESTADO_W*c +: ESTADO_W] = est[c];
    assign calefactor[c] = est[c] == CALENTANDO;
    assign ventilador[c] = est[c] == ENFRIANDO || est[c] == ALERTA;
    assign alerta[c]     = est[c] == ALERTA;
  end

  assign alerta_global = |alerta;

endmodule

// File: tb/tb_monitoreo_temperatura_multicanal.sv
// Directed bench for monitoreo_temperatura_multicanal with three channels.
module tb_monitoreo_temperatura_multicanal;

  localparam int N = 3;
  localparam int A = 11;
  localparam int CW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 temp_valido;
  logic [1:0]           canal_id;
  logic signed [A-1:0]  temp_entrada;
  logic signed [A-1:0]  umbral_bajo, umbral_alto, umbral_critico;
  logic [N-1:0]         calefactor, ventilador, alerta;
  logic                 alerta_global;
  logic [2*N-1:0]       estado_actual;
  logic [CW*N-1:0]      contador_salida;

  int comparados = 0;
  int errores    = 0;

  always #5 clk = ~clk;

  monitoreo_temperatura_multicanal #(
    .N_CANALES(N), .ANCHO(A), .PERSISTENCIA(3), .HISTERESIS(2), .CONT_W(CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .temp_valido     (temp_valido),
    .canal_id        (canal_id),
    .temp_entrada    (temp_entrada),
    .umbral_bajo     (umbral_bajo),
    .umbral_alto     (umbral_alto),
    .umbral_critico  (umbral_critico),
    .calefactor      (calefactor),
    .ventilador      (ventilador),
    .alerta          (alerta),
    .alerta_global   (alerta_global),
    .estado_actual   (estado_actual),
    .contador_salida (contador_salida)
  );

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    comparados++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  // Present one valid sample; returns #1 after the capturing edge.
  task automatic muestra(input logic [1:0] c, input int v);
    @(negedge clk);
    temp_valido  = 1'b1;
    canal_id     = c;
    temp_entrada = A'(v);
    @(posedge clk);
    #1;
    temp_valido = 1'b0;
  endtask

  task automatic ver(input string tag, input int est, input int cnt,
                     input int cal, input int ven, input int ale, input int glo);
    comprobar({tag, ".estado"},  32'(estado_actual),   32'(est));
    comprobar({tag, ".cont"},    32'(contador_salida), 32'(cnt));
    comprobar({tag, ".calef"},   32'(calefactor),      32'(cal));
    comprobar({tag, ".vent"},    32'(ventilador),      32'(ven));
    comprobar({tag, ".alerta"},  32'(alerta),          32'(ale));
    comprobar({tag, ".global"},  32'(alerta_global),   32'(glo));
  endtask

  initial begin
    umbral_bajo    = 11'sd15;
    umbral_alto    = 11'sd30;
    umbral_critico = 11'sd45;
    rst            = 1'b1;
    temp_valido    = 1'b1;
    canal_id       = 2'd0;
    temp_entrada   = 11'sd50;
    repeat (3) @(posedge clk);
    #1;
    ver("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst         = 1'b0;
    temp_valido = 1'b0;

    // Channel 1 heats up past umbral_alto
    muestra(2'd1, 35); ver("c1_s1", 0, 8, 0, 0, 0, 0);
    muestra(2'd1, 35); ver("c1_s2", 0, 16, 0, 0, 0, 0);
    muestra(2'd1, 35); ver("c1_s3", 8, 0, 0, 3'b010, 0, 0);

    // Hysteresis exit from ENFRIANDO at 28
    muestra(2'd1, 29); ver("c1_h29", 8, 0, 0, 3'b010, 0, 0);
    muestra(2'd1, 28); ver("c1_h28", 0, 0, 0, 0, 0, 0);

    // Persistence restart on channel 2, then critical at the exact threshold
    muestra(2'd2, 35); ver("c2_s1", 0, 64, 0, 0, 0, 0);
    muestra(2'd2, 35); ver("c2_s2", 0, 128, 0, 0, 0, 0);
    muestra(2'd2, 20); ver("c2_s3", 0, 0, 0, 0, 0, 0);
    muestra(2'd2, 35); ver("c2_s4", 0, 64, 0, 0, 0, 0);
    muestra(2'd2, 45); ver("c2_c1", 0, 64, 0, 0, 0, 0);
    muestra(2'd2, 45); ver("c2_c2", 0, 128, 0, 0, 0, 0);

    // Channel 0 critical entry and hysteresis exit to ENFRIANDO
    muestra(2'd0, 50); ver("c0_a1", 0, 129, 0, 0, 0, 0);
    muestra(2'd0, 50); ver("c0_a2", 0, 130, 0, 0, 0, 0);
    muestra(2'd0, 50); ver("c0_a3", 3, 128, 0, 3'b001, 3'b001, 1);
    muestra(2'd0, 44); ver("c0_h44", 3, 128, 0, 3'b001, 3'b001, 1);
    muestra(2'd0, 43); ver("c0_h43", 2, 128, 0, 3'b001, 0, 0);

    // Cold: first sample exits ENFRIANDO, then three more enter CALENTANDO
    muestra(2'd0, -100); ver("c0_f0", 0, 128, 0, 0, 0, 0);
    muestra(2'd0, -100); ver("c0_f1", 0, 129, 0, 0, 0, 0);
    muestra(2'd0, -100); ver("c0_f2", 0, 130, 0, 0, 0, 0);
    muestra(2'd0, -100); ver("c0_f3", 1, 128, 3'b001, 0, 0, 0);

    // Out-of-range channel id is ignored
    muestra(2'd3, 50); ver("id3", 1, 128, 3'b001, 0, 0, 0);

    // Reset wins over a simultaneous valid sample
    @(negedge clk);
    rst          = 1'b1;
    temp_valido  = 1'b1;
    canal_id     = 2'd1;
    temp_entrada = 11'sd50;
    @(posedge clk);
    #1;
    ver("rst_mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst         = 1'b0;
    temp_valido = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, errores);
    $finish;
  end

endmodule
